// File: rtl/regression_accumulator.sv
// Streams N_SAMPLES (x, y) pairs from the loader and accumulates sum x, y, xy, xx for the regression solver.
// Optional saturation with a sticky overflow flag when ACC_SAT_EN is defined.
module regression_accumulator #(
   parameter int unsigned N_SAMPLES = 150,
   parameter int unsigned DW        = 20,
   parameter int unsigned SW        = 28,
   parameter int unsigned PW        = 48,
   parameter int unsigned CW        = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 inc_vector,
   input  logic signed [DW-1:0] vect_x,
   input  logic signed [DW-1:0] vect_y,
   output logic                 busy,
   output logic                 done,
   output logic [CW-1:0]        count,
   output logic signed [SW-1:0] sum_x,
   output logic signed [SW-1:0] sum_y,
   output logic signed [PW-1:0] sum_xy,
   output logic signed [PW-1:0] sum_xx,
   output logic                 overflow
);

   localparam int unsigned PRW = 2 * DW;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   localparam logic [CW-1:0] REQ_LAST = CW'(N_SAMPLES - 1);

   logic [1:0]           state_q, state_d;
   logic [CW-1:0]        req_cnt_q, req_cnt_d;
   logic                 inc_vector_q, inc_vector_d;
   logic                 acc_valid_q, acc_valid_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [CW-1:0]        count_q, count_d;
   logic signed [SW-1:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
   logic signed [PW-1:0] sum_xy_q, sum_xy_d, sum_xx_q, sum_xx_d;

   logic signed [PRW-1:0] prod_xy, prod_xx;
   logic signed [SW-1:0]  nx, ny;
   logic signed [PW-1:0]  nxy, nxx;

   // Operands widened first so the full 2*DW signed product is kept
   always_comb begin
      prod_xy = PRW'(vect_x) * PRW'(vect_y);
      prod_xx = PRW'(vect_x) * PRW'(vect_x);
   end

`ifdef ACC_SAT_EN
   logic overflow_q, overflow_d;
   logic ox, oy, oxy, oxx;

   function automatic logic [SW:0] sat_add_sw(input logic signed [SW-1:0] a,
                                              input logic signed [SW-1:0] b);
      logic signed [SW-1:0] s;
      logic                 o;
      s = a + b;
      o = (a[SW-1] == b[SW-1]) && (s[SW-1] != a[SW-1]);
      if (o) s = a[SW-1] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
      return {o, s};
   endfunction

   function automatic logic [PW:0] sat_add_pw(input logic signed [PW-1:0] a,
                                              input logic signed [PW-1:0] b);
      logic signed [PW-1:0] s;
      logic                 o;
      s = a + b;
      o = (a[PW-1] == b[PW-1]) && (s[PW-1] != a[PW-1]);
      if (o) s = a[PW-1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
      return {o, s};
   endfunction

   always_comb begin
      {ox, nx}   = sat_add_sw(sum_x_q, SW'(vect_x));
      {oy, ny}   = sat_add_sw(sum_y_q, SW'(vect_y));
      {oxy, nxy} = sat_add_pw(sum_xy_q, PW'(prod_xy));
      {oxx, nxx} = sat_add_pw(sum_xx_q, PW'(prod_xx));
   end
`else
   always_comb begin
      nx  = sum_x_q + SW'(vect_x);
      ny  = sum_y_q + SW'(vect_y);
      nxy = sum_xy_q + PW'(prod_xy);
      nxx = sum_xx_q + PW'(prod_xx);
   end
`endif

   // Next-state, request and accumulation logic
   always_comb begin
      state_d      = state_q;
      req_cnt_d    = req_cnt_q;
      inc_vector_d = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      acc_valid_d  = inc_vector_q;
      count_d      = count_q;
      sum_x_d      = sum_x_q;
      sum_y_d      = sum_y_q;
      sum_xy_d     = sum_xy_q;
      sum_xx_d     = sum_xx_q;
`ifdef ACC_SAT_EN
      overflow_d   = overflow_q;
`endif

      if (acc_valid_q) begin
         sum_x_d  = nx;
         sum_y_d  = ny;
         sum_xy_d = nxy;
         sum_xx_d = nxx;
         count_d  = count_q + CW'(1);
`ifdef ACC_SAT_EN
         overflow_d = overflow_q | ox | oy | oxy | oxx;
`endif
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d      = S_RUN;
               req_cnt_d    = '0;
               inc_vector_d = 1'b1;
               busy_d       = 1'b1;
               count_d      = '0;
               sum_x_d      = '0;
               sum_y_d      = '0;
               sum_xy_d     = '0;
               sum_xx_d     = '0;
`ifdef ACC_SAT_EN
               overflow_d   = 1'b0;
`endif
            end
         end
         S_RUN: begin
            busy_d = 1'b1;
            if (req_cnt_q == REQ_LAST) begin
               state_d = S_DRAIN;
            end else begin
               inc_vector_d = 1'b1;
               req_cnt_d    = req_cnt_q + CW'(1);
            end
         end
         S_DRAIN: begin
            state_d = S_DONE;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         req_cnt_q    <= '0;
         inc_vector_q <= 1'b0;
         acc_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         count_q      <= '0;
         sum_x_q      <= '0;
         sum_y_q      <= '0;
         sum_xy_q     <= '0;
         sum_xx_q     <= '0;
      end else begin
         state_q      <= state_d;
         req_cnt_q    <= req_cnt_d;
         inc_vector_q <= inc_vector_d;
         acc_valid_q  <= acc_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         count_q      <= count_d;
         sum_x_q      <= sum_x_d;
         sum_y_q      <= sum_y_d;
         sum_xy_q     <= sum_xy_d;
         sum_xx_q     <= sum_xx_d;
      end
   end

`ifdef ACC_SAT_EN
   always_ff @(posedge clk) begin
      if (rst) overflow_q <= 1'b0;
      else     overflow_q <= overflow_d;
   end
   assign overflow = overflow_q;
`else
   assign overflow = 1'b0;
`endif

   assign inc_vector = inc_vector_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign count      = count_q;
   assign sum_x      = sum_x_q;
   assign sum_y      = sum_y_q;
   assign sum_xy     = sum_xy_q;
   assign sum_xx     = sum_xx_q;

endmodule

// File: tb/tb_regression_accumulator.sv
// Directed scoreboard bench for regression_accumulator with a registered loader model.
module tb_regression_accumulator;

   localparam int unsigned N   = 4;
   localparam int unsigned DW  = 20;
   localparam int unsigned SW  = 28;
   localparam int unsigned PW  = 48;
   localparam int unsigned CW  = 8;
   localparam int unsigned SW2 = 21;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic start2 = 1'b0;
   always #5 clk = ~clk;

   logic                 inc_vector, busy, done, overflow;
   logic [CW-1:0]        count;
   logic signed [DW-1:0] vx, vy;
   logic signed [SW-1:0] sum_x, sum_y;
   logic signed [PW-1:0] sum_xy, sum_xx;

   logic                  inc_vector2, busy2, done2, overflow2;
   logic [CW-1:0]         count2;
   logic signed [DW-1:0]  vx2, vy2;
   logic signed [SW2-1:0] sum_x2, sum_y2;
   logic signed [PW-1:0]  sum_xy2, sum_xx2;

   regression_accumulator #(.N_SAMPLES(N), .DW(DW), .SW(SW), .PW(PW), .CW(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .inc_vector(inc_vector),
      .vect_x(vx), .vect_y(vy), .busy(busy), .done(done), .count(count),
      .sum_x(sum_x), .sum_y(sum_y), .sum_xy(sum_xy), .sum_xx(sum_xx),
      .overflow(overflow));

   regression_accumulator #(.N_SAMPLES(N), .DW(DW), .SW(SW2), .PW(PW), .CW(CW)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .inc_vector(inc_vector2),
      .vect_x(vx2), .vect_y(vy2), .busy(busy2), .done(done2), .count(count2),
      .sum_x(sum_x2), .sum_y(sum_y2), .sum_xy(sum_xy2), .sum_xx(sum_xx2),
      .overflow(overflow2));

   // Loader models: register the next table entry on each request
   logic signed [DW-1:0] tx [4];
   logic signed [DW-1:0] ty [4];
   logic [1:0]           lidx;
   always @(posedge clk) begin
      if (rst) begin
         lidx <= '0; vx <= '0; vy <= '0;
      end else if (inc_vector) begin
         vx   <= tx[lidx];
         vy   <= ty[lidx];
         lidx <= lidx + 2'd1;
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         vx2 <= '0; vy2 <= '0;
      end else if (inc_vector2) begin
         vx2 <= 20'sd524287;
         vy2 <= '0;
      end
   end

   typedef struct {
      longint sx;
      longint sy;
      longint sxy;
      longint sxx;
      longint cnt;
   } exp_t;
   exp_t sb[$];

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input longint obs, input longint exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic run_check(input string tag, input bit mid_start);
      exp_t e;
      int   cyc, inc_cnt;
      bit   seen;
      e = '{0, 0, 0, 0, longint'(N)};
      for (int i = 0; i < 4; i++) begin
         e.sx  += longint'(tx[i]);
         e.sy  += longint'(ty[i]);
         e.sxy += longint'(tx[i]) * longint'(ty[i]);
         e.sxx += longint'(tx[i]) * longint'(tx[i]);
      end
      sb.push_back(e);

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_start"}, longint'(busy), 1);
      check({tag, "_count_clr"}, longint'(count), 0);
      check({tag, "_sxy_clr"}, longint'(sum_xy), 0);

      cyc = 0; inc_cnt = 0; seen = 1'b0;
      while (cyc < 30 && !seen) begin
         if (inc_vector) inc_cnt++;
         if (done) begin
            seen = 1'b1;
         end else begin
            if (mid_start) start = (cyc == 1);
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      check({tag, "_done_cycle"}, longint'(cyc), longint'(N + 1));
      check({tag, "_inc_cycles"}, longint'(inc_cnt), longint'(N));

      e = sb.pop_front();
      check({tag, "_sum_x"}, longint'(sum_x), e.sx);
      check({tag, "_sum_y"}, longint'(sum_y), e.sy);
      check({tag, "_sum_xy"}, longint'(sum_xy), e.sxy);
      check({tag, "_sum_xx"}, longint'(sum_xx), e.sxx);
      check({tag, "_count"}, longint'(count), e.cnt);
      check({tag, "_busy_done"}, longint'(busy), 0);
      check({tag, "_overflow"}, longint'(overflow), 0);

      @(negedge clk);
      check({tag, "_done_pulse"}, longint'(done), 0);
      check({tag, "_hold_sxx"}, longint'(sum_xx), e.sxx);
   endtask

   initial begin
      int idle_inc;
      int cyc;
      bit seen;
      longint exp_sx2, exp_ov2;

      tx = '{20'sd1, 20'sd2, 20'sd3, 20'sd4};
      ty = '{20'sd2, 20'sd4, 20'sd6, 20'sd8};

      // Reset for two cycles
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_inc", longint'(inc_vector), 0);
      check("rst_busy", longint'(busy), 0);
      check("rst_done", longint'(done), 0);
      check("rst_count", longint'(count), 0);
      check("rst_sum_x", longint'(sum_x), 0);
      check("rst_sum_y", longint'(sum_y), 0);
      check("rst_sum_xy", longint'(sum_xy), 0);
      check("rst_sum_xx", longint'(sum_xx), 0);
      check("rst_overflow", longint'(overflow), 0);
      rst = 1'b0;

      idle_inc = 0;
      repeat (10) begin
         @(negedge clk);
         if (inc_vector) idle_inc++;
      end
      check("idle_inc", longint'(idle_inc), 0);

      run_check("pos", 1'b0);

      // Back-to-back signed run
      tx = '{-20'sd1, -20'sd2, -20'sd3, -20'sd4};
      ty = '{20'sd5, 20'sd5, 20'sd5, 20'sd5};
      run_check("signed", 1'b0);

      tx = '{20'sd7, -20'sd3, 20'sd100, -20'sd524288};
      ty = '{-20'sd9, 20'sd11, 20'sd524287, -20'sd2};
      run_check("midstart", 1'b1);

      // Reset in RUN cycle 2
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mrst_inc", longint'(inc_vector), 0);
      check("mrst_busy", longint'(busy), 0);
      check("mrst_count", longint'(count), 0);
      check("mrst_sum_x", longint'(sum_x), 0);
      check("mrst_sum_xx", longint'(sum_xx), 0);
      rst = 1'b0;
      @(negedge clk);

      tx = '{20'sd1, 20'sd2, 20'sd3, 20'sd4};
      ty = '{20'sd2, 20'sd4, 20'sd6, 20'sd8};
      run_check("after_rst", 1'b0);

      // Narrow sum_x accumulator driven past its range
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      cyc = 0; seen = 1'b0;
      while (cyc < 30 && !seen) begin
         if (done2) seen = 1'b1;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
`ifdef ACC_SAT_EN
      exp_sx2 = 1048575;
      exp_ov2 = 1;
`else
      exp_sx2 = -4;
      exp_ov2 = 0;
`endif
      check("ovf_done_cycle", longint'(cyc), longint'(N + 1));
      check("ovf_sum_x", longint'(sum_x2), exp_sx2);
      check("ovf_flag", longint'(overflow2), exp_ov2);
      check("ovf_sum_y", longint'(sum_y2), 0);
      check("ovf_sum_xy", longint'(sum_xy2), 0);
      check("ovf_sum_xx", longint'(sum_xx2), 64'sd1099507433476);
      check("ovf_count", longint'(count2), longint'(N));
      check("ovf_busy", longint'(busy2), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
